// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the load/store unit: dmctrl codes, FSM states, byte-enable helper.
package riscv_mem_pkg;

    localparam logic [2:0] DM_B  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_W  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b100;
    localparam logic [2:0] DM_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        LWAIT,
        RESP
    } lsu_state_t;

    // Byte enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] lsu_byte_en(input logic [2:0] ctrl, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (ctrl)
            DM_B, DM_BU: be = 4'b0001 << addr_lo;
            DM_H, DM_HU: be = 4'b0011 << {addr_lo[1], 1'b0};
            default:     be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts the addressed lane down and sign/zero-extends it.
module lsu_load_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  ctrl_i,
    output logic [31:0] result_c
);

    logic [15:0] lane_c;

    // Bring the addressed byte/half down to bit 0.
    always_comb begin
        lane_c = 16'(rdata_i >> {addr_lo_i, 3'b000});
    end

    // Extend according to access size and signedness.
    always_comb begin
        result_c = rdata_i;
        case (ctrl_i)
            DM_B:    result_c = {{24{lane_c[7]}}, lane_c[7:0]};
            DM_BU:   result_c = {24'h000000, lane_c[7:0]};
            DM_H:    result_c = {{16{lane_c[15]}}, lane_c[15:0]};
            DM_HU:   result_c = {16'h0000, lane_c[15:0]};
            default: result_c = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-organised data memory.
// One request per transaction; faulting requests complete without a memory access.
module load_store_unit
    import riscv_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    localparam int unsigned AW = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_ctrl,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_fault,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    lsu_state_t    state_q, state_d;
    logic          we_q, we_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic [1:0]    addr_lo_q, addr_lo_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_fault_q, rsp_fault_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_re_q, mem_re_d;
    logic          mem_we_q, mem_we_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;

    logic          req_fault_c;
    logic [31:0]   store_data_c;
    logic [31:0]   load_data_c;
    logic          unused_addr_hi;

    // Word index wraps: address bits above the memory are ignored.
    assign unused_addr_hi = ^req_addr[31:AW+2];

    assign req_ready = (state_q == IDLE) && !rst;

    // Illegal dmctrl codes and misaligned half/word accesses.
    always_comb begin
        req_fault_c = 1'b0;
        case (req_ctrl)
            DM_B, DM_BU: req_fault_c = 1'b0;
            DM_H, DM_HU: req_fault_c = req_addr[0];
            DM_W:        req_fault_c = (req_addr[1:0] != 2'b00);
            default:     req_fault_c = 1'b1;
        endcase
    end

    // Replicate store data across all lanes it may land in.
    always_comb begin
        case (req_ctrl)
            DM_B, DM_BU: store_data_c = {4{req_wdata[7:0]}};
            DM_H, DM_HU: store_data_c = {2{req_wdata[15:0]}};
            default:     store_data_c = req_wdata;
        endcase
    end

    lsu_load_align u_load_align (
        .rdata_i   (mem_rdata),
        .addr_lo_i (addr_lo_q),
        .ctrl_i    (ctrl_q),
        .result_c  (load_data_c)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        ctrl_d      = ctrl_q;
        addr_lo_d   = addr_lo_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0;
        rsp_fault_d = 1'b0;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    we_d      = req_we;
                    ctrl_d    = req_ctrl;
                    addr_lo_d = req_addr[1:0];
                    if (req_fault_c) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        mem_re_d    = !req_we;
                        mem_we_d    = req_we;
                        mem_addr_d  = req_addr[AW+1:2];
                        mem_be_d    = req_we ? lsu_byte_en(req_ctrl, req_addr[1:0]) : 4'b1111;
                        mem_wdata_d = store_data_c;
                    end
                end
            end
            ACCESS: begin
                state_d     = we_q ? RESP : LWAIT;
                rsp_valid_d = we_q;
            end
            LWAIT: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_data_c;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            ctrl_q      <= 3'b000;
            addr_lo_q   <= 2'b00;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_fault_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            ctrl_q      <= ctrl_d;
            addr_lo_q   <= addr_lo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fault_q <= rsp_fault_d;
            mem_addr_q  <= mem_addr_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;
    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule
